video_timing_gen: RTL and testbench

Parametrised raster timing generator for the arcade video path. It is the successor to the fixed 384×263 sync generator: total, active, sync and position-origin values are parameters, and it runs on the system clock with a pixel clock-enable instead of a derived pixel clock. It adds runtime screen-centering shifts and line/frame strobes. It sits between the game core (supplies RGB for HPOS/VPOS) and arcade_video (consumes RGB, blanks, syncs).

---
 rtl/video_timing_gen.sv | 111 +++++++++++
 tb/tb_video_timing_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: H/V counters on a pixel clock-enable,
// blanking/sync decoded from the next count, frame-latched sync shifts, line/frame strobes.
module video_timing_gen #(
    parameter int CNT_W        = 9,
    parameter int RGB_W        = 12,
    parameter int H_TOTAL      = 384,
    parameter int H_ACT_START  = 16,
    parameter int H_ACT_END    = 272,
    parameter int H_SYNC_START = 312,
    parameter int H_SYNC_END   = 344,
    parameter int V_TOTAL      = 263,
    parameter int V_ACT_START  = 16,
    parameter int V_ACT_END    = 240,
    parameter int V_SYNC_START = 244,
    parameter int V_SYNC_END   = 252,
    parameter int POS_ORG      = 16
) (
    input  logic             MCLK,
    input  logic             RESET_N,
    input  logic             PCE,
    input  logic [3:0]       H_SHIFT,
    input  logic [3:0]       V_SHIFT,
    input  logic [RGB_W-1:0] iRGB,
    output logic [CNT_W-1:0] HPOS,
    output logic [CNT_W-1:0] VPOS,
    output logic [RGB_W-1:0] oRGB,
    output logic             HBLK,
    output logic             VBLK,
    output logic             HSYN,
    output logic             VSYN,
    output logic             LINE_STB,
    output logic             FRAME_STB
);

    if (!(H_ACT_START < H_ACT_END && H_ACT_END <= H_TOTAL &&
          H_SYNC_START < H_SYNC_END && H_SYNC_START - 8 >= 0 && H_SYNC_END + 7 <= H_TOTAL &&
          V_ACT_START < V_ACT_END && V_ACT_END <= V_TOTAL &&
          V_SYNC_START < V_SYNC_END && V_SYNC_START - 8 >= 0 && V_SYNC_END + 7 <= V_TOTAL &&
          H_TOTAL <= 2**CNT_W && V_TOTAL <= 2**CNT_W &&
          POS_ORG >= 0 && POS_ORG < 2**CNT_W)) begin : g_param_check
        $error("video_timing_gen: illegal timing parameters");
    end

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_AS   = CNT_W'(H_ACT_START);
    localparam logic [CNT_W-1:0] H_AE   = CNT_W'(H_ACT_END);
    localparam logic [CNT_W-1:0] V_AS   = CNT_W'(V_ACT_START);
    localparam logic [CNT_W-1:0] V_AE   = CNT_W'(V_ACT_END);
    localparam logic [CNT_W-1:0] ORG    = CNT_W'(POS_ORG);
    localparam logic signed [CNT_W:0] H_SS = (CNT_W+1)'(H_SYNC_START);
    localparam logic signed [CNT_W:0] H_SE = (CNT_W+1)'(H_SYNC_END);
    localparam logic signed [CNT_W:0] V_SS = (CNT_W+1)'(V_SYNC_START);
    localparam logic signed [CNT_W:0] V_SE = (CNT_W+1)'(V_SYNC_END);

    logic [CNT_W-1:0] hcnt, vcnt, h_next, v_next;
    logic [3:0]       hs, vs, hs_next, vs_next;
    logic             run, h_wrap, v_wrap;
    logic signed [CNT_W:0] h_sx, v_sx, hs_ext, vs_ext;

    // The first PCE after reset "enters" 0,0 so a frame strobe opens the first frame.
    always_comb begin
        h_wrap  = !run || (hcnt == H_LAST);
        v_wrap  = !run || (h_wrap && (vcnt == V_LAST));
        h_next  = h_wrap ? '0 : hcnt + 1'b1;
        v_next  = v_wrap ? '0 : (h_wrap ? vcnt + 1'b1 : vcnt);
        hs_next = v_wrap ? H_SHIFT : hs;
        vs_next = v_wrap ? V_SHIFT : vs;
        h_sx    = $signed({1'b0, h_next});
        v_sx    = $signed({1'b0, v_next});
        hs_ext  = {{(CNT_W-3){hs_next[3]}}, hs_next};
        vs_ext  = {{(CNT_W-3){vs_next[3]}}, vs_next};
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            run       <= 1'b0;
            hcnt      <= '0;
            vcnt      <= '0;
            hs        <= '0;
            vs        <= '0;
            HBLK      <= 1'b1;
            VBLK      <= 1'b1;
            HSYN      <= 1'b1;
            VSYN      <= 1'b1;
            oRGB      <= '0;
            LINE_STB  <= 1'b0;
            FRAME_STB <= 1'b0;
        end else if (PCE) begin
            run       <= 1'b1;
            hcnt      <= h_next;
            vcnt      <= v_next;
            hs        <= hs_next;
            vs        <= vs_next;
            HBLK      <= !(h_next >= H_AS && h_next < H_AE);
            VBLK      <= !(v_next >= V_AS && v_next < V_AE);
            HSYN      <= !(h_sx >= H_SS + hs_ext && h_sx < H_SE + hs_ext);
            VSYN      <= !(v_sx >= V_SS + vs_ext && v_sx < V_SE + vs_ext);
            oRGB      <= (HBLK || VBLK) ? '0 : iRGB;
            LINE_STB  <= h_wrap;
            FRAME_STB <= v_wrap;
        end else begin
            LINE_STB  <= 1'b0;
            FRAME_STB <= 1'b0;
        end
    end

    assign HPOS = hcnt - ORG;
    assign VPOS = vcnt - ORG;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a reduced raster (40x24) to keep frames short.
module tb_video_timing_gen;
    localparam int HT = 40, HAS = 4, HAE = 30, HSS = 12, HSE = 20;
    localparam int VT = 24, VAS = 4, VAE = 18, VSS = 9, VSE = 12;
    localparam int PO = 4;

    logic        MCLK = 1'b0, RESET_N = 1'b0, PCE = 1'b0;
    logic [3:0]  H_SHIFT = '0, V_SHIFT = '0;
    logic [11:0] iRGB = '0;
    logic [8:0]  HPOS, VPOS;
    logic [11:0] oRGB;
    logic        HBLK, VBLK, HSYN, VSYN, LINE_STB, FRAME_STB;

    always #5 MCLK = ~MCLK;

    video_timing_gen #(
        .CNT_W(9), .RGB_W(12),
        .H_TOTAL(HT), .H_ACT_START(HAS), .H_ACT_END(HAE), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_TOTAL(VT), .V_ACT_START(VAS), .V_ACT_END(VAE), .V_SYNC_START(VSS), .V_SYNC_END(VSE),
        .POS_ORG(PO)
    ) dut (
        .MCLK(MCLK), .RESET_N(RESET_N), .PCE(PCE), .H_SHIFT(H_SHIFT), .V_SHIFT(V_SHIFT),
        .iRGB(iRGB), .HPOS(HPOS), .VPOS(VPOS), .oRGB(oRGB), .HBLK(HBLK), .VBLK(VBLK),
        .HSYN(HSYN), .VSYN(VSYN), .LINE_STB(LINE_STB), .FRAME_STB(FRAME_STB)
    );

    typedef struct {
        logic [8:0]  hpos, vpos;
        logic [11:0] rgb;
        logic        hblk, vblk, hsyn, vsyn, line, frame;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0;

    int   mh, mv, mhs, mvs;
    bit   mrun;
    logic mhblk, mvblk, mhsyn, mvsyn, mline, mframe;
    logic [11:0] mrgb;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; mhs = 0; mvs = 0; mrun = 0;
        mhblk = 1; mvblk = 1; mhsyn = 1; mvsyn = 1; mline = 0; mframe = 0; mrgb = '0;
    endtask

    task automatic model_update(bit pce);
        mline = 0; mframe = 0;
        if (!pce) return;
        mrgb = (mhblk || mvblk) ? 12'h000 : iRGB;
        if (!mrun) begin
            mrun = 1; mh = 0; mv = 0; mline = 1; mframe = 1;
        end else begin
            mh = mh + 1;
            if (mh == HT) begin
                mh = 0; mline = 1; mv = mv + 1;
                if (mv == VT) begin mv = 0; mframe = 1; end
            end
        end
        if (mframe) begin
            mhs = int'($signed(H_SHIFT));
            mvs = int'($signed(V_SHIFT));
        end
        mhblk = !(mh >= HAS && mh < HAE);
        mvblk = !(mv >= VAS && mv < VAE);
        mhsyn = !(mh >= HSS + mhs && mh < HSE + mhs);
        mvsyn = !(mv >= VSS + mvs && mv < VSE + mvs);
    endtask

    task automatic push_exp();
        exp_t e;
        e.hpos = 9'(mh - PO);
        e.vpos = 9'(mv - PO);
        e.rgb  = mrgb;
        e.hblk = mhblk; e.vblk = mvblk; e.hsyn = mhsyn; e.vsyn = mvsyn;
        e.line = mline; e.frame = mframe;
        q.push_back(e);
    endtask

    task automatic compare_pop();
        exp_t e;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = q.pop_front();
        chk("hpos", HPOS, e.hpos);
        chk("vpos", VPOS, e.vpos);
        chk("orgb", oRGB, e.rgb);
        chk("hblk", HBLK, e.hblk);
        chk("vblk", VBLK, e.vblk);
        chk("hsyn", HSYN, e.hsyn);
        chk("vsyn", VSYN, e.vsyn);
        chk("line_stb", LINE_STB, e.line);
        chk("frame_stb", FRAME_STB, e.frame);
    endtask

    task automatic step(bit pce);
        @(negedge MCLK);
        PCE  = pce;
        iRGB = 12'($urandom);
        @(posedge MCLK);
        model_update(pce);
        push_exp();
        #1 compare_pop();
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_hpos"}, HPOS, 9'd508);
        chk({tag, "_vpos"}, VPOS, 9'd508);
        chk({tag, "_orgb"}, oRGB, 12'h000);
        chk({tag, "_hblk"}, HBLK, 1'b1);
        chk({tag, "_vblk"}, VBLK, 1'b1);
        chk({tag, "_hsyn"}, HSYN, 1'b1);
        chk({tag, "_vsyn"}, VSYN, 1'b1);
        chk({tag, "_line"}, LINE_STB, 1'b0);
        chk({tag, "_frame"}, FRAME_STB, 1'b0);
    endtask

    initial begin
        int lines, n, fall_pos;
        bit seen, found;

        model_reset();
        #23 chk_reset("reset");
        @(negedge MCLK) RESET_N = 1'b1;

        step(1);
        chk("first_pce_frame_stb", FRAME_STB, 1'b1);
        repeat (2 * HT * VT - 1) step(1);

        // Shift changed mid-frame: only the following frame may use it.
        repeat (HT * VT / 2) step(1);
        H_SHIFT = 4'd5;
        V_SHIFT = 4'hD;
        repeat (HT * VT / 2 + HT) step(1);
        found = 0; fall_pos = -1;
        for (int i = 0; i < HT && !found; i++) begin
            step(1);
            if (!HSYN) begin found = 1; fall_pos = int'(HPOS); end
        end
        chk("hsyn_fall_shifted", 32'(fall_pos), 32'(HSS + 5 - PO));
        repeat (HT * VT) step(1);

        // PCE on every 4th MCLK: count lines between two frame strobes.
        n = 0; seen = 0;
        while (!seen && n < 8000) begin
            step(n % 4 == 0);
            n++;
            if (FRAME_STB) seen = 1;
        end
        chk("slow_frame_found", 32'(seen), 32'd1);
        lines = 0; seen = 0; n = 0;
        while (!seen && n < 5000) begin
            step(n % 4 == 3);
            n++;
            if (LINE_STB) lines++;
            if (FRAME_STB) seen = 1;
        end
        chk("slow_lines_per_frame", 32'(lines), 32'(VT));

        // Asynchronous reset pulse between clock edges, mid-line.
        n = 0;
        while (!(mh == 10 && mv == 5) && n < 5000) begin step(1); n++; end
        chk("reached_h10_v5", 32'(mh * 100 + mv), 32'd1005);
        RESET_N = 1'b0;
        #1 chk_reset("async_reset");
        #1 RESET_N = 1'b1;
        model_reset();
        step(1);
        chk("post_reset_frame_stb", FRAME_STB, 1'b1);

        repeat (1500) step(1'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
